axi_read_master: RTL and testbench

//  AXI4 read-channel master: turns a simple start/addr/len command into one INCR burst
//  on the AR channel, collects the R-channel beats and signals completion.

---
 rtl/axi_read_master.sv | 115 +++++++++++
 tb/tb_axi_read_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_master.sv
// AXI4 read-channel master: issues one INCR burst per start command, forwards each
// received beat to the client and reports completion with the burst's error status.
module axi_read_master #(
    parameter int ADDR_WIDTH         = 32,
    parameter int READ_CHANNEL_WIDTH = 32,
    parameter int READ_BURST_LEN     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_read,
    input  logic [ADDR_WIDTH-1:0]         target_read_addr,
    input  logic [READ_BURST_LEN-1:0]     target_read_burst_len,
    output logic                          done_read,
    output logic [READ_CHANNEL_WIDTH-1:0] rd_data,
    output logic                          rd_data_valid,
    output logic                          read_err,
    input  logic                          ARREADY,
    output logic [ADDR_WIDTH-1:0]         ARADDR,
    output logic                          ARVALID,
    output logic [READ_BURST_LEN-1:0]     ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic [1:0]                    ARBURST,
    input  logic                          RVALID,
    input  logic [READ_CHANNEL_WIDTH-1:0] RDATA,
    input  logic                          RLAST,
    input  logic [1:0]                    RRESP,
    output logic                          RREADY
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    // One extra counter bit so beats past a full 2^N burst cannot alias back to zero.
    localparam logic [READ_BURST_LEN:0] CNT_ONE = 1;
    localparam logic [2:0] SIZE_ENC = 3'($clog2(READ_CHANNEL_WIDTH / 8));

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           araddr_q, araddr_d;
    logic [READ_BURST_LEN-1:0]       arlen_q, arlen_d;
    logic [READ_CHANNEL_WIDTH-1:0]   rdata_q, rdata_d;
    logic                            rdv_q, rdv_d;
    logic                            err_q, err_d;
    logic [READ_BURST_LEN:0]         cnt_q, cnt_d;
    logic                            len_mismatch;

    // cnt_q is the index of the beat being accepted this cycle.
    assign len_mismatch = RLAST ? (cnt_q != {1'b0, arlen_q})
                                : (cnt_q >= {1'b0, arlen_q});

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        rdata_d  = rdata_q;
        rdv_d    = 1'b0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_read) begin
                    araddr_d = target_read_addr;
                    arlen_d  = target_read_burst_len;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ARREADY) state_d = S_DATA;
            end
            S_DATA: begin
                if (RVALID) begin
                    rdata_d = RDATA;
                    rdv_d   = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (RRESP != 2'b00 || len_mismatch) err_d = 1'b1;
                    if (RLAST) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            araddr_q <= '0;
            arlen_q  <= '0;
            rdata_q  <= '0;
            rdv_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            rdata_q  <= rdata_d;
            rdv_q    <= rdv_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ARVALID       = (state_q == S_ADDR);
    assign RREADY        = (state_q == S_DATA);
    assign done_read     = (state_q == S_DONE);
    assign ARADDR        = araddr_q;
    assign ARLEN         = arlen_q;
    assign ARSIZE        = SIZE_ENC;
    assign ARBURST       = 2'b01;
    assign rd_data       = rdata_q;
    assign rd_data_valid = rdv_q;
    assign read_err      = err_q;

endmodule

// File: tb/tb_axi_read_master.sv
// Bench for axi_read_master: the slave driver schedules, per cycle, what every output
// must be; a negedge process compares the DUT against that timeline.
module tb_axi_read_master;

    localparam int NC = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_read;
    logic [31:0] target_read_addr;
    logic [7:0]  target_read_burst_len;
    logic        done_read;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        read_err;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        RVALID;
    logic [31:0] RDATA;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic        RREADY;

    axi_read_master dut (
        .clk(clk), .rst(rst), .start_read(start_read),
        .target_read_addr(target_read_addr), .target_read_burst_len(target_read_burst_len),
        .done_read(done_read), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .read_err(read_err), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARVALID(ARVALID),
        .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .RVALID(RVALID),
        .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected timeline, indexed by cycle; unset entries mean "output must be 0".
    bit          exp_arv  [NC];
    logic [31:0] exp_addr [NC];
    logic [7:0]  exp_len  [NC];
    bit          exp_rr   [NC];
    bit          exp_rdv  [NC];
    logic [31:0] exp_rdata[NC];
    bit          exp_done [NC];
    bit          err_chk  [NC];
    bit          err_val  [NC];

    int errors = 0;
    int checks = 0;
    int rdv_cnt = 0;
    int done_cnt = 0;
    bit chk_en = 0;
    bit last_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < NC) begin
            chk("ARVALID", 64'(ARVALID), 64'(exp_arv[cyc]));
            if (exp_arv[cyc]) begin
                chk("ARADDR", 64'(ARADDR), 64'(exp_addr[cyc]));
                chk("ARLEN", 64'(ARLEN), 64'(exp_len[cyc]));
            end
            chk("ARSIZE", 64'(ARSIZE), 64'd2);
            chk("ARBURST", 64'(ARBURST), 64'd1);
            chk("RREADY", 64'(RREADY), 64'(exp_rr[cyc]));
            chk("rd_data_valid", 64'(rd_data_valid), 64'(exp_rdv[cyc]));
            if (exp_rdv[cyc]) chk("rd_data", 64'(rd_data), 64'(exp_rdata[cyc]));
            chk("done_read", 64'(done_read), 64'(exp_done[cyc]));
            if (err_chk[cyc]) chk("read_err", 64'(read_err), 64'(err_val[cyc]));
            if (rd_data_valid === 1'b1) rdv_cnt++;
            if (done_read === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            err_chk[cyc] = 1'b1;
            err_val[cyc] = last_err;
            tick();
        end
    endtask

    // Drives one command and its R beats. nb is the beat count the slave actually
    // returns (RLAST on the last one); err_beat gets RRESP=SLVERR; abort_at pulses rst
    // in place of that beat. Returns in the first IDLE cycle after done_read.
    task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input int ardly,
                             input int gap_pct, input int err_beat, input int nb,
                             input int abort_at);
        logic [31:0] d;
        logic [1:0]  resp;
        bit          anyerr;
        int          b;
        err_chk[cyc] = 1'b1;
        err_val[cyc] = last_err;
        start_read = 1'b1;
        target_read_addr = a;
        target_read_burst_len = l;
        tick();
        start_read = 1'b0;
        target_read_addr = $urandom;
        target_read_burst_len = 8'($urandom);
        for (int i = 0; i <= ardly; i++) begin
            exp_arv[cyc] = 1'b1;
            exp_addr[cyc] = a;
            exp_len[cyc] = l;
            ARREADY = (i == ardly);
            tick();
        end
        ARREADY = 1'b0;
        anyerr = 1'b0;
        b = 0;
        while (b < nb) begin
            exp_rr[cyc] = 1'b1;
            if (b == abort_at) begin
                rst = 1'b1;
                RVALID = 1'b0;
                tick();
                rst = 1'b0;
                last_err = 1'b0;
                return;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                RVALID = 1'b0;
                RDATA = $urandom;
                RLAST = 1'($urandom);
                RRESP = 2'b11;
            end else begin
                d = $urandom;
                resp = (b == err_beat) ? 2'b10 : 2'b00;
                RVALID = 1'b1;
                RDATA = d;
                RRESP = resp;
                RLAST = (b == nb - 1);
                exp_rdv[cyc + 1] = 1'b1;
                exp_rdata[cyc + 1] = d;
                anyerr = anyerr | (resp != 2'b00);
                b++;
            end
            tick();
        end
        RVALID = 1'b0;
        RLAST = 1'b0;
        RRESP = 2'b00;
        last_err = anyerr || (nb != int'(l) + 1);
        exp_done[cyc] = 1'b1;
        err_chk[cyc] = 1'b1;
        err_val[cyc] = last_err;
        tick();
    endtask

    initial begin
        int r0, d0, len, nb;
        rst = 1'b1;
        start_read = 1'b0;
        target_read_addr = '0;
        target_read_burst_len = '0;
        ARREADY = 1'b0;
        RVALID = 1'b0;
        RDATA = '0;
        RLAST = 1'b0;
        RRESP = 2'b00;
        repeat (3) tick();
        chk("rst_ARVALID", 64'(ARVALID), 64'd0);
        chk("rst_RREADY", 64'(RREADY), 64'd0);
        chk("rst_done", 64'(done_read), 64'd0);
        chk("rst_rdv", 64'(rd_data_valid), 64'd0);
        chk("rst_err", 64'(read_err), 64'd0);
        chk("rst_ARADDR", 64'(ARADDR), 64'd0);
        chk("rst_ARLEN", 64'(ARLEN), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        r0 = rdv_cnt; d0 = done_cnt;
        run_burst(32'd123, 8'd3, 0, 0, -1, 4, -1);
        chk("t1_beats", 64'(rdv_cnt - r0), 64'd4);
        chk("t1_done", 64'(done_cnt - d0), 64'd1);
        chk("t1_err", 64'(read_err), 64'd0);

        d0 = done_cnt;
        run_burst(32'd5, 8'd0, 0, 0, -1, 1, -1);
        run_burst(32'd789, 8'd1, 0, 0, -1, 2, -1);
        chk("t3_done", 64'(done_cnt - d0), 64'd2);

        r0 = rdv_cnt; d0 = done_cnt;
        run_burst(32'h0000_4000, 8'd5, 3, 40, -1, 6, -1);
        chk("t4_beats", 64'(rdv_cnt - r0), 64'd6);
        chk("t4_done", 64'(done_cnt - d0), 64'd1);
        idle(1);

        run_burst(32'h0000_0100, 8'd3, 0, 0, 1, 4, -1);
        chk("t5_err", 64'(read_err), 64'd1);
        run_burst(32'h0000_0200, 8'd2, 1, 0, -1, 3, -1);
        chk("t5_clear", 64'(read_err), 64'd0);

        d0 = done_cnt;
        run_burst(32'h0000_0300, 8'd7, 1, 20, -1, 8, 3);
        chk("t6_ARADDR", 64'(ARADDR), 64'd0);
        chk("t6_ARLEN", 64'(ARLEN), 64'd0);
        chk("t6_rd_data", 64'(rd_data), 64'd0);
        chk("t6_err", 64'(read_err), 64'd0);
        idle(2);
        chk("t6_nodone", 64'(done_cnt - d0), 64'd0);
        run_burst(32'h0000_0400, 8'd2, 0, 10, -1, 3, -1);
        chk("t6_fresh", 64'(done_cnt - d0), 64'd1);

        run_burst(32'h0000_0500, 8'd4, 0, 0, -1, 3, -1);
        chk("early_last", 64'(read_err), 64'd1);
        run_burst(32'h0000_0600, 8'd2, 0, 0, -1, 4, -1);
        chk("late_last", 64'(read_err), 64'd1);

        r0 = rdv_cnt;
        run_burst(32'h0001_0000, 8'd255, 2, 5, -1, 256, -1);
        chk("max_beats", 64'(rdv_cnt - r0), 64'd256);
        chk("max_err", 64'(read_err), 64'd0);

        for (int k = 0; k < 40; k++) begin
            len = int'($urandom_range(15));
            nb = len + 1;
            if ($urandom_range(7) == 0) nb = (len > 0 && $urandom_range(1) == 0) ? len : len + 2;
            run_burst($urandom, 8'(len), int'($urandom_range(4)), int'($urandom_range(50)),
                      ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1, nb, -1);
            idle(int'($urandom_range(2)));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
